// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays req_amount from 15 stocked denominations, largest first.
// Latency: one SCAN cycle per code tried. Backpressure: EMIT holds the coin until coin_ready.
module change_dispenser #(
    parameter int AMT_W       = 20,
    parameter int CNT_W       = 16,
    parameter int INIT_CNT_1  = 100,
    parameter int INIT_CNT_2  = 100,
    parameter int INIT_CNT_3  = 100,
    parameter int INIT_CNT_4  = 100,
    parameter int INIT_CNT_5  = 100,
    parameter int INIT_CNT_6  = 100,
    parameter int INIT_CNT_7  = 100,
    parameter int INIT_CNT_8  = 100,
    parameter int INIT_CNT_9  = 100,
    parameter int INIT_CNT_10 = 100,
    parameter int INIT_CNT_11 = 100,
    parameter int INIT_CNT_12 = 100,
    parameter int INIT_CNT_13 = 100,
    parameter int INIT_CNT_14 = 100,
    parameter int INIT_CNT_15 = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             coin_valid,
    output logic [3:0]       coin_code,
    input  logic             coin_ready,
    input  logic             refill_valid,
    input  logic [3:0]       refill_code,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

    state_t           state;
    logic [3:0]       index;
    logic [CNT_W-1:0] stock [0:15];

    function automatic logic [AMT_W-1:0] value_of(input logic [3:0] code);
        case (code)
            4'd1:    value_of = AMT_W'(50000);
            4'd2:    value_of = AMT_W'(20000);
            4'd3:    value_of = AMT_W'(10000);
            4'd4:    value_of = AMT_W'(5000);
            4'd5:    value_of = AMT_W'(2000);
            4'd6:    value_of = AMT_W'(1000);
            4'd7:    value_of = AMT_W'(500);
            4'd8:    value_of = AMT_W'(200);
            4'd9:    value_of = AMT_W'(100);
            4'd10:   value_of = AMT_W'(50);
            4'd11:   value_of = AMT_W'(25);
            4'd12:   value_of = AMT_W'(10);
            4'd13:   value_of = AMT_W'(5);
            4'd14:   value_of = AMT_W'(2);
            4'd15:   value_of = AMT_W'(1);
            default: value_of = '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] init_of(input int k);
        case (k)
            1:       init_of = CNT_W'(INIT_CNT_1);
            2:       init_of = CNT_W'(INIT_CNT_2);
            3:       init_of = CNT_W'(INIT_CNT_3);
            4:       init_of = CNT_W'(INIT_CNT_4);
            5:       init_of = CNT_W'(INIT_CNT_5);
            6:       init_of = CNT_W'(INIT_CNT_6);
            7:       init_of = CNT_W'(INIT_CNT_7);
            8:       init_of = CNT_W'(INIT_CNT_8);
            9:       init_of = CNT_W'(INIT_CNT_9);
            10:      init_of = CNT_W'(INIT_CNT_10);
            11:      init_of = CNT_W'(INIT_CNT_11);
            12:      init_of = CNT_W'(INIT_CNT_12);
            13:      init_of = CNT_W'(INIT_CNT_13);
            14:      init_of = CNT_W'(INIT_CNT_14);
            15:      init_of = CNT_W'(INIT_CNT_15);
            default: init_of = '0;
        endcase
    endfunction

    logic [AMT_W-1:0] cur_val;
    logic             can_emit;
    logic             coin_take;

    assign cur_val   = value_of(index);
    assign can_emit  = (cur_val <= remaining) && (stock[index] != '0);
    assign coin_take = (state == EMIT) && coin_ready;

    // A coin leaves only after can_emit saw stock > 0, so the decrement never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) stock[k] <= init_of(k);
        end else begin
            stock[0] <= '0;
            for (int k = 1; k < 16; k++) begin
                if (refill_valid && refill_code == 4'(k) && !(coin_take && index == 4'(k))) begin
                    if (stock[k] != '1) stock[k] <= stock[k] + 1'b1;
                end else if (coin_take && index == 4'(k) && !(refill_valid && refill_code == 4'(k))) begin
                    stock[k] <= stock[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            coin_valid <= 1'b0;
            coin_code  <= 4'd0;
            done       <= 1'b0;
            short      <= 1'b0;
            remaining  <= '0;
            index      <= 4'd1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        remaining <= req_amount;
                        index     <= 4'd1;
                        short     <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (remaining == '0) begin
                        short <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (can_emit) begin
                        coin_valid <= 1'b1;
                        coin_code  <= index;
                        state      <= EMIT;
                    end else if (index == 4'd15) begin
                        short <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        index <= index + 4'd1;
                    end
                end
                EMIT: begin
                    // Index is kept so the same denomination is retried before moving on.
                    if (coin_ready) begin
                        remaining  <= remaining - cur_val;
                        coin_valid <= 1'b0;
                        coin_code  <= 4'd0;
                        state      <= SCAN;
                    end
                end
                FIN: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: default-stock instance plus a sparse-stock instance.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, coin_valid, coin_ready, refill_valid, done, short;
    logic [19:0] req_amount, remaining;
    logic [3:0]  coin_code, refill_code;

    logic        b_req_valid, b_req_ready, b_coin_valid, b_done, b_short;
    logic [19:0] b_req_amount, b_remaining;
    logic [3:0]  b_coin_code;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] coins[$];

    always #5 clk = ~clk;

    change_dispenser dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .coin_valid(coin_valid), .coin_code(coin_code), .coin_ready(coin_ready),
        .refill_valid(refill_valid), .refill_code(refill_code),
        .done(done), .short(short), .remaining(remaining)
    );

    change_dispenser #(
        .INIT_CNT_1(0), .INIT_CNT_2(0), .INIT_CNT_3(0), .INIT_CNT_4(0), .INIT_CNT_5(0),
        .INIT_CNT_6(0), .INIT_CNT_7(0), .INIT_CNT_8(0), .INIT_CNT_9(0), .INIT_CNT_10(0),
        .INIT_CNT_11(0), .INIT_CNT_12(0), .INIT_CNT_13(0), .INIT_CNT_14(1), .INIT_CNT_15(0)
    ) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_amount(b_req_amount), .req_ready(b_req_ready),
        .coin_valid(b_coin_valid), .coin_code(b_coin_code), .coin_ready(1'b1),
        .refill_valid(1'b0), .refill_code(4'd0),
        .done(b_done), .short(b_short), .remaining(b_remaining)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on dut_a and collect handshaken coin codes until done.
    task automatic run_a(input logic [19:0] amt);
        coins.delete();
        req_valid  = 1'b1;
        req_amount = amt;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (coin_valid && coin_ready) coins.push_back(coin_code);
            if (done) break;
            tick();
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_coin();
        for (int i = 0; i < 100; i++) begin
            if (coin_valid) break;
            tick();
        end
        check("coin_seen", 32'(coin_valid), 32'd1);
    endtask

    initial begin
        int exp_codes[7] = '{6, 7, 8, 9, 10, 11, 12};
        reset = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ready = 1'b1;
        refill_valid = 1'b0; refill_code = '0;
        b_req_valid = 1'b0; b_req_amount = '0;
        tick(); tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_coin_valid", 32'(coin_valid), 32'd0);
        check("rst_coin_code", 32'(coin_code), 32'd0);
        check("rst_done_short", 32'({done, short}), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_stock9", 32'(dut_a.stock[9]), 32'd100);
        reset = 1'b0;
        tick();

        // 1885 = 1000+500+200+100+50+25+10
        run_a(20'd1885);
        check("g_num_coins", 32'(coins.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check("g_code", (i < coins.size()) ? 32'(coins[i]) : 32'd0, 32'(exp_codes[i]));
        check("g_short", 32'(short), 32'd0);
        check("g_remaining", 32'(remaining), 32'd0);
        for (int k = 6; k <= 12; k++) check("g_stock", 32'(dut_a.stock[k]), 32'd99);
        check("g_stock13", 32'(dut_a.stock[13]), 32'd100);
        tick();
        check("g_done_pulse", 32'(done), 32'd0);
        check("g_req_ready", 32'(req_ready), 32'd1);
        check("g_short_hold", 32'(short), 32'd0);

        // zero request
        req_valid = 1'b1; req_amount = 20'd0;
        tick();
        req_valid = 1'b0;
        check("z_cyc1", 32'({done, coin_valid}), 32'd0);
        tick();
        check("z_cyc2_done", 32'({done, coin_valid}), 32'b10);
        check("z_short", 32'(short), 32'd0);
        tick();
        check("z_done_low", 32'(done), 32'd0);

        // 500 with ejector stalled for 5 cycles
        coin_ready = 1'b0;
        req_valid = 1'b1; req_amount = 20'd500;
        tick();
        req_valid = 1'b0;
        wait_coin();
        for (int i = 0; i < 5; i++) begin
            check("s_hold", 32'({coin_valid, coin_code}), 32'h17);
            if (i < 4) tick();
        end
        coin_ready = 1'b1;
        coins.delete();
        for (int i = 0; i < 50; i++) begin
            if (coin_valid) coins.push_back(coin_code);
            if (done) break;
            tick();
        end
        check("s_done", 32'(done), 32'd1);
        check("s_num_coins", 32'(coins.size()), 32'd1);
        check("s_remaining", 32'(remaining), 32'd0);
        check("s_stock7", 32'(dut_a.stock[7]), 32'd98);

        // refill colliding with a code-9 dispense
        reset = 1'b1; tick(); reset = 1'b0; tick();
        coin_ready = 1'b0;
        req_valid = 1'b1; req_amount = 20'd100;
        tick();
        req_valid = 1'b0;
        wait_coin();
        check("r_code", 32'(coin_code), 32'd9);
        coin_ready = 1'b1; refill_valid = 1'b1; refill_code = 4'd9;
        tick();
        refill_code = 4'd0;
        check("r_stock9_net", 32'(dut_a.stock[9]), 32'd100);
        tick();
        refill_code = 4'd3;
        check("r_code0_s1", 32'(dut_a.stock[1]), 32'd100);
        check("r_code0_s15", 32'(dut_a.stock[15]), 32'd100);
        tick();
        refill_valid = 1'b0;
        check("r_stock3_inc", 32'(dut_a.stock[3]), 32'd101);
        check("r_req_ready", 32'(req_ready), 32'd1);

        // reset while a coin is offered
        coin_ready = 1'b0;
        req_valid = 1'b1; req_amount = 20'd500;
        tick();
        req_valid = 1'b0;
        wait_coin();
        reset = 1'b1;
        tick();
        check("x_coin_valid", 32'(coin_valid), 32'd0);
        check("x_req_ready", 32'(req_ready), 32'd1);
        for (int k = 1; k <= 15; k++) check("x_stock", 32'(dut_a.stock[k]), 32'd100);
        reset = 1'b0;
        coin_ready = 1'b1;
        tick();

        // sparse stock: only one 2-cent coin, request 3
        coins.delete();
        b_req_valid = 1'b1; b_req_amount = 20'd3;
        tick();
        b_req_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_coin_valid) coins.push_back(b_coin_code);
            if (b_done) break;
            tick();
        end
        check("b_done", 32'(b_done), 32'd1);
        check("b_num_coins", 32'(coins.size()), 32'd1);
        check("b_code", (coins.size() > 0) ? 32'(coins[0]) : 32'd0, 32'd14);
        check("b_short", 32'(b_short), 32'd1);
        check("b_remaining", 32'(b_remaining), 32'd1);
        check("b_stock14", 32'(dut_b.stock[14]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
